cdc_tx_arbiter: RTL and testbench

Message-granular arbiter that shares the single USB CDC IN byte stream (`usb_cdc` `in_data_i`/`in_valid_i`/`in_ready_o`) among several byte-stream requesters, such as banner generators and status reporters. A grant covers one whole message, delimited by a `last` flag, so text lines never interleave on the host terminal. Arbitration is round-robin. An optional stall timeout reclaims the stream from a requester that goes silent mid-message. The block sits in the application clock domain (`app_clk_i` side of `usb_cdc`), between the requesters and the CDC core.

---
 rtl/cdc_arb_pkg.sv | 18 +
 rtl/rr_pick.sv | 42 ++++
 rtl/cdc_tx_arbiter.sv | 188 ++++++++++++++++++
 tb/tb_cdc_tx_arbiter.sv | 354 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cdc_arb_pkg.sv
// -----------------------------------------------------------------------------
// cdc_arb_pkg
// Shared definitions for the USB CDC transmit arbiter:
//   - arb_state_e : arbiter FSM states (ARB_IDLE, ARB_BUSY)
//   - MAX_REQ     : largest supported number of requesters
//   - BYTE_W      : width of one stream byte
// -----------------------------------------------------------------------------
package cdc_arb_pkg;

    localparam int MAX_REQ = 8;
    localparam int BYTE_W  = 8;

    typedef enum logic [0:0] {
        ARB_IDLE = 1'b0,
        ARB_BUSY = 1'b1
    } arb_state_e;

endpackage : cdc_arb_pkg

// File: rtl/rr_pick.sv
// -----------------------------------------------------------------------------
// rr_pick
// Combinational round-robin priority picker. Starting at index ptr and
// searching upward (wrapping modulo NUM_REQ), the first set request bit wins.
//
// Ports:
//   req     in  NUM_REQ  request vector
//   ptr     in  PTR_W    index with highest priority (must be < NUM_REQ)
//   gnt     out NUM_REQ  one-hot winner, zero when no request
//   any_req out 1        at least one request bit is set
// -----------------------------------------------------------------------------
module rr_pick
    import cdc_arb_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int PTR_W   = 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [PTR_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] gnt,
    output logic               any_req
);

    logic [NUM_REQ-1:0] rot_s;
    logic [NUM_REQ-1:0] pick_s;
    logic               found_s;

    // Rotate so ptr lands on bit 0, take the lowest set bit, rotate back.
    always_comb begin
        rot_s   = NUM_REQ'({req, req} >> ptr);
        pick_s  = '0;
        found_s = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            pick_s[i] = rot_s[i] & ~found_s;
            found_s   = found_s | rot_s[i];
        end
        gnt = NUM_REQ'(({pick_s, pick_s} << ptr) >> NUM_REQ);
    end

    assign any_req = |req;

endmodule : rr_pick

// File: rtl/cdc_tx_arbiter.sv
// -----------------------------------------------------------------------------
// cdc_tx_arbiter
// Message-granular round-robin arbiter sharing the single USB CDC IN byte
// stream among NUM_REQ byte-stream requesters. A grant lasts for a whole
// message (ended by a transferred byte with last set), so lines from
// different sources never interleave. One IDLE bubble separates messages.
//
// Optional feature (macro CDC_TX_ARB_TIMEOUT_EN): a stall counter revokes the
// grant after TIMEOUT_CYCLES consecutive cycles in which the owner shows no
// valid byte. Back-pressure (valid high, in_ready_i low) never counts.
//
// Ports:
//   clk_i        in   application clock
//   rstn_i       in   asynchronous active-low reset
//   req_data_i   in   8*NUM_REQ  byte per requester, k at [8k+7:8k]
//   req_valid_i  in   NUM_REQ    byte valid per requester
//   req_last_i   in   NUM_REQ    byte ends the message
//   req_ready_o  out  NUM_REQ    byte accepted (owner only)
//   in_data_o    out  8          byte to usb_cdc
//   in_valid_o   out  1          valid to usb_cdc
//   in_ready_i   in   1          ready from usb_cdc
//   grant_o      out  NUM_REQ    one-hot current owner, zero when idle
//   busy_o       out  1          message in progress
//   timeout_o    out  1          one-cycle pulse on timeout revocation
// -----------------------------------------------------------------------------
module cdc_tx_arbiter
    import cdc_arb_pkg::*;
#(
    parameter int NUM_REQ        = 2,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                      clk_i,
    input  logic                      rstn_i,
    input  logic [BYTE_W*NUM_REQ-1:0] req_data_i,
    input  logic [NUM_REQ-1:0]        req_valid_i,
    input  logic [NUM_REQ-1:0]        req_last_i,
    output logic [NUM_REQ-1:0]        req_ready_o,
    output logic [BYTE_W-1:0]         in_data_o,
    output logic                      in_valid_o,
    input  logic                      in_ready_i,
    output logic [NUM_REQ-1:0]        grant_o,
    output logic                      busy_o,
    output logic                      timeout_o
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    // Reject illegal configurations at elaboration time.
    if (NUM_REQ < 1 || NUM_REQ > MAX_REQ || TIMEOUT_CYCLES < 2) begin : g_bad_param
        $error("cdc_tx_arbiter: illegal NUM_REQ or TIMEOUT_CYCLES");
    end

    arb_state_e          state_r, state_s;
    logic [NUM_REQ-1:0]  grant_r, grant_s;
    logic [PTR_W-1:0]    ptr_r, ptr_s;
    logic [NUM_REQ-1:0]  pick_gnt_s;
    logic                pick_any_s;
    logic [PTR_W-1:0]    owner_idx_s;
    logic [PTR_W-1:0]    ptr_after_s;
    logic [BYTE_W-1:0]   sel_data_s;
    logic                sel_valid_s;
    logic                sel_last_s;
    logic                busy_s;
    logic                xfer_s;
    logic                timeout_fire_s;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) u_pick (
        .req     (req_valid_i),
        .ptr     (ptr_r),
        .gnt     (pick_gnt_s),
        .any_req (pick_any_s)
    );

    // One-hot AND-OR mux of the owner's data/valid/last plus owner index;
    // everything reads zero while grant_r is empty.
    always_comb begin
        sel_data_s  = '0;
        sel_valid_s = 1'b0;
        sel_last_s  = 1'b0;
        owner_idx_s = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            sel_data_s  = sel_data_s | ({BYTE_W{grant_r[k]}} & req_data_i[k*BYTE_W +: BYTE_W]);
            sel_valid_s = sel_valid_s | (grant_r[k] & req_valid_i[k]);
            sel_last_s  = sel_last_s | (grant_r[k] & req_last_i[k]);
            owner_idx_s = owner_idx_s | (grant_r[k] ? PTR_W'(k) : PTR_W'(0));
        end
    end

    assign busy_s      = (state_r == ARB_BUSY);
    assign xfer_s      = busy_s & sel_valid_s & in_ready_i;
    assign ptr_after_s = (owner_idx_s == PTR_W'(NUM_REQ - 1)) ? '0 : (owner_idx_s + PTR_W'(1));

`ifdef CDC_TX_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] stall_cnt_r, stall_cnt_s;
    logic             timeout_r;

    // Stall counter: counts owner-silent cycles in BUSY, fires on the cycle
    // that would bring it to TIMEOUT_CYCLES.
    always_comb begin
        stall_cnt_s    = '0;
        timeout_fire_s = 1'b0;
        if (busy_s && !sel_valid_s) begin
            if (stall_cnt_r == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                timeout_fire_s = 1'b1;
                stall_cnt_s    = '0;
            end else begin
                stall_cnt_s    = stall_cnt_r + CNT_W'(1);
            end
        end else begin
            stall_cnt_s = '0;
        end
    end

    // Stall counter and timeout pulse registers.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            stall_cnt_r <= '0;
            timeout_r   <= 1'b0;
        end else begin
            stall_cnt_r <= stall_cnt_s;
            timeout_r   <= timeout_fire_s;
        end
    end

    assign timeout_o = timeout_r;
`else
    assign timeout_fire_s = 1'b0;
    assign timeout_o      = 1'b0;
`endif

    // Next-state logic: arbitrate in IDLE, release on last transfer or timeout.
    always_comb begin
        state_s = state_r;
        grant_s = grant_r;
        ptr_s   = ptr_r;
        case (state_r)
            ARB_IDLE: begin
                if (pick_any_s) begin
                    state_s = ARB_BUSY;
                    grant_s = pick_gnt_s;
                end else begin
                    state_s = ARB_IDLE;
                    grant_s = '0;
                end
            end
            ARB_BUSY: begin
                if ((xfer_s && sel_last_s) || timeout_fire_s) begin
                    state_s = ARB_IDLE;
                    grant_s = '0;
                    ptr_s   = ptr_after_s;
                end else begin
                    state_s = ARB_BUSY;
                end
            end
            default: begin
                state_s = ARB_IDLE;
                grant_s = '0;
                ptr_s   = '0;
            end
        endcase
    end

    // FSM state, owner and round-robin pointer registers.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_r <= ARB_IDLE;
            grant_r <= '0;
            ptr_r   <= '0;
        end else begin
            state_r <= state_s;
            grant_r <= grant_s;
            ptr_r   <= ptr_s;
        end
    end

    // Stream path is a combinational pass-through of the owner.
    assign busy_o      = busy_s;
    assign grant_o     = grant_r;
    assign in_valid_o  = busy_s & sel_valid_s;
    assign in_data_o   = busy_s ? sel_data_s : '0;
    assign req_ready_o = busy_s ? (grant_r & {NUM_REQ{in_ready_i}}) : '0;

endmodule : cdc_tx_arbiter

// File: tb/tb_cdc_tx_arbiter.sv
// -----------------------------------------------------------------------------
// tb_cdc_tx_arbiter
// Self-checking bench for cdc_tx_arbiter (3 requesters, TIMEOUT_CYCLES=16).
// A cycle-level reference model (owner / pointer / stall count as plain ints)
// predicts every output each cycle; directed steps add explicit checks on the
// logged output history. Honors CDC_TX_ARB_TIMEOUT_EN.
// -----------------------------------------------------------------------------
module tb_cdc_tx_arbiter;

    localparam int N       = 3;
    localparam int T       = 16;
    localparam int LOG_LEN = 8192;
`ifdef CDC_TX_ARB_TIMEOUT_EN
    localparam bit TMO_EN = 1'b1;
`else
    localparam bit TMO_EN = 1'b0;
`endif

    logic           clk       = 1'b0;
    logic           rstn      = 1'b1;
    logic [8*N-1:0] req_data  = '0;
    logic [N-1:0]   req_valid = '0;
    logic [N-1:0]   req_last  = '0;
    logic [N-1:0]   req_ready;
    logic [7:0]     in_data;
    logic           in_valid;
    logic           in_ready  = 1'b0;
    logic [N-1:0]   grant;
    logic           busy;
    logic           timeout;

    int checks = 0;
    int errors = 0;

    cdc_tx_arbiter #(.NUM_REQ(N), .TIMEOUT_CYCLES(T)) dut (
        .clk_i       (clk),
        .rstn_i      (rstn),
        .req_data_i  (req_data),
        .req_valid_i (req_valid),
        .req_last_i  (req_last),
        .req_ready_o (req_ready),
        .in_data_o   (in_data),
        .in_valid_o  (in_valid),
        .in_ready_i  (in_ready),
        .grant_o     (grant),
        .busy_o      (busy),
        .timeout_o   (timeout)
    );

    always #5 clk = ~clk;

    // requester side: queued bytes {last, data}
    logic [8:0] rq [N][$];
    bit         present [N];
    int         gap [N];
    bit         rand_gaps = 1'b0;

    // reference model
    int m_owner = -1;
    int m_ptr   = 0;
    int m_stall = 0;
    bit m_tmo   = 1'b0;

    // output history
    int           cyc = 0;
    logic [7:0]   lg_data  [LOG_LEN];
    logic         lg_valid [LOG_LEN];
    logic         lg_busy  [LOG_LEN];
    logic         lg_tmo   [LOG_LEN];
    logic [N-1:0] lg_grant [LOG_LEN];
    logic [N-1:0] lg_ready [LOG_LEN];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input int k, input logic [7:0] b, input logic l);
        rq[k].push_back({l, b});
    endtask

    task automatic drive();
        for (int k = 0; k < N; k++) begin
            if (!present[k] && gap[k] == 0 && rq[k].size() > 0) present[k] = 1'b1;
            req_valid[k] = present[k];
            if (present[k]) begin
                req_data[k*8 +: 8] = rq[k][0][7:0];
                req_last[k]        = rq[k][0][8];
            end else begin
                req_data[k*8 +: 8] = 8'($urandom);
                req_last[k]        = 1'($urandom);
            end
        end
    endtask

    task automatic run_cycle();
        logic [N-1:0] e_grant;
        logic [N-1:0] e_ready;
        logic         e_valid;
        logic [7:0]   e_data;
        int           acc;
        drive();
        @(negedge clk);
        e_grant = '0;
        e_ready = '0;
        e_valid = 1'b0;
        e_data  = 8'h00;
        if (m_owner >= 0) begin
            e_grant[m_owner] = 1'b1;
            e_valid          = req_valid[m_owner];
            e_data           = req_data[m_owner*8 +: 8];
            if (in_ready) e_ready[m_owner] = 1'b1;
        end
        chk("busy",     32'(busy),      32'(m_owner >= 0));
        chk("grant",    32'(grant),     32'(e_grant));
        chk("in_valid", 32'(in_valid),  32'(e_valid));
        chk("in_data",  32'(in_data),   32'(e_data));
        chk("ready",    32'(req_ready), 32'(e_ready));
        chk("timeout",  32'(timeout),   32'(m_tmo));
        if (cyc < LOG_LEN) begin
            lg_data[cyc]  = in_data;
            lg_valid[cyc] = in_valid;
            lg_busy[cyc]  = busy;
            lg_tmo[cyc]   = timeout;
            lg_grant[cyc] = grant;
            lg_ready[cyc] = req_ready;
        end
        acc = (m_owner >= 0 && req_valid[m_owner] && in_ready) ? m_owner : -1;
        @(posedge clk);
        // model update from the rules: pick in idle, release on last/timeout
        m_tmo = 1'b0;
        if (m_owner < 0) begin
            for (int s = 0; s < N; s++) begin
                if (m_owner < 0 && req_valid[(m_ptr + s) % N]) m_owner = (m_ptr + s) % N;
            end
        end else if (req_valid[m_owner] && in_ready && req_last[m_owner]) begin
            m_ptr   = (m_owner + 1) % N;
            m_owner = -1;
            m_stall = 0;
        end else if (req_valid[m_owner]) begin
            m_stall = 0;
        end else if (TMO_EN) begin
            m_stall++;
            if (m_stall == T) begin
                m_tmo   = 1'b1;
                m_ptr   = (m_owner + 1) % N;
                m_owner = -1;
                m_stall = 0;
            end
        end
        for (int k = 0; k < N; k++) begin
            if (!present[k] && gap[k] > 0) gap[k]--;
        end
        if (acc >= 0) begin
            void'(rq[acc].pop_front());
            present[acc] = 1'b0;
            gap[acc]     = rand_gaps ? int'($urandom_range(0, 3)) : 0;
        end
        cyc++;
        #1;
    endtask

    task automatic reset_dut();
        rstn = 1'b0;
        for (int k = 0; k < N; k++) begin
            rq[k].delete();
            present[k] = 1'b0;
            gap[k]     = 0;
        end
        req_valid = '0;
        req_last  = '0;
        m_owner   = -1;
        m_ptr     = 0;
        m_stall   = 0;
        m_tmo     = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy",  32'(busy),      32'd0);
        chk("rst_grant", 32'(grant),     32'd0);
        chk("rst_valid", 32'(in_valid),  32'd0);
        chk("rst_ready", 32'(req_ready), 32'd0);
        rstn = 1'b1;
    endtask

    initial begin
        int c;
        int held;
        int tmo_seen;
        int left;
        int k;
        int len;

        // power-on reset with requests already asserted
        #1;
        rstn      = 1'b0;
        req_valid = '1;
        req_last  = '1;
        req_data  = 24'h5AA55A;
        in_ready  = 1'b1;
        #2;
        chk("por_busy",    32'(busy),      32'd0);
        chk("por_grant",   32'(grant),     32'd0);
        chk("por_valid",   32'(in_valid),  32'd0);
        chk("por_ready",   32'(req_ready), 32'd0);
        chk("por_data",    32'(in_data),   32'd0);
        chk("por_timeout", 32'(timeout),   32'd0);
        @(posedge clk);
        #1;
        chk("por_grant_edge", 32'(grant), 32'd0);
        reset_dut();

        // 1: single requester "Hi\n"
        in_ready = 1'b1;
        c = cyc;
        push(0, 8'h48, 1'b0);
        push(0, 8'h69, 1'b0);
        push(0, 8'h0A, 1'b1);
        repeat (6) run_cycle();
        chk("t1_idle_valid", 32'(lg_valid[c]),   32'd0);
        chk("t1_b0",         32'(lg_data[c+1]),  32'h48);
        chk("t1_b0_valid",   32'(lg_valid[c+1]), 32'd1);
        chk("t1_b1",         32'(lg_data[c+2]),  32'h69);
        chk("t1_b2",         32'(lg_data[c+3]),  32'h0A);
        chk("t1_busy_last",  32'(lg_busy[c+3]),  32'd1);
        chk("t1_busy_fall",  32'(lg_busy[c+4]),  32'd0);

        // 2: round robin with two contending requesters
        reset_dut();
        c = cyc;
        push(0, 8'hA0, 1'b0); push(0, 8'hA1, 1'b1);
        push(0, 8'hA2, 1'b0); push(0, 8'hA3, 1'b1);
        push(1, 8'hB0, 1'b0); push(1, 8'hB1, 1'b1);
        repeat (11) run_cycle();
        chk("t2_first",   32'(lg_grant[c+1]), 32'b001);
        chk("t2_a1",      32'(lg_data[c+2]),  32'hA1);
        chk("t2_bubble",  32'(lg_busy[c+3]),  32'd0);
        chk("t2_second",  32'(lg_grant[c+4]), 32'b010);
        chk("t2_b0",      32'(lg_data[c+4]),  32'hB0);
        chk("t2_bubble2", 32'(lg_busy[c+6]),  32'd0);
        chk("t2_third",   32'(lg_grant[c+7]), 32'b001);
        chk("t2_a3",      32'(lg_data[c+8]),  32'hA3);

        // 3: no interleaving while another requester waits
        reset_dut();
        c = cyc;
        for (int i = 0; i < 4; i++) push(0, 8'(8'hC0 + i), (i == 3));
        push(1, 8'hD0, 1'b1);
        repeat (9) run_cycle();
        for (int i = 1; i <= 4; i++) begin
            chk("t3_rdy1", 32'(lg_ready[c+i][1]), 32'd0);
            chk("t3_data", 32'(lg_data[c+i]),     32'(8'hC0 + i - 1));
        end
        chk("t3_bubble", 32'(lg_busy[c+5]),  32'd0);
        chk("t3_req1",   32'(lg_grant[c+6]), 32'b010);
        chk("t3_d0",     32'(lg_data[c+6]),  32'hD0);

        // 4: long back-pressure does not time out
        reset_dut();
        c = cyc;
        push(0, 8'h11, 1'b0); push(0, 8'h22, 1'b0); push(0, 8'h33, 1'b1);
        in_ready = 1'b1;
        repeat (2) run_cycle();
        in_ready = 1'b0;
        repeat (2000) run_cycle();
        in_ready = 1'b1;
        repeat (4) run_cycle();
        held = 0;
        tmo_seen = 0;
        for (int i = c + 2; i < c + 2002; i++) begin
            if (lg_data[i] == 8'h22 && lg_valid[i] && lg_busy[i]) held++;
            if (lg_tmo[i]) tmo_seen++;
        end
        chk("t4_held",     32'(held),            32'd2000);
        chk("t4_no_tmo",   32'(tmo_seen),        32'd0);
        chk("t4_stall_rd", 32'(lg_ready[c+2]),   32'd0);
        chk("t4_b1",       32'(lg_data[c+2002]), 32'h22);
        chk("t4_b2",       32'(lg_data[c+2003]), 32'h33);
        chk("t4_done",     32'(lg_busy[c+2004]), 32'd0);

        // 5: owner goes silent mid-message
        reset_dut();
        c = cyc;
        push(0, 8'h5A, 1'b0);
        push(1, 8'hB0, 1'b1);
        repeat (22) run_cycle();
        chk("t5_first", 32'(lg_data[c+1]), 32'h5A);
`ifdef CDC_TX_ARB_TIMEOUT_EN
        chk("t5_tmo_pre",   32'(lg_tmo[c+17]),   32'd0);
        chk("t5_tmo",       32'(lg_tmo[c+18]),   32'd1);
        chk("t5_tmo_post",  32'(lg_tmo[c+19]),   32'd0);
        chk("t5_idle",      32'(lg_busy[c+18]),  32'd0);
        chk("t5_req1",      32'(lg_grant[c+19]), 32'b010);
        chk("t5_req1_data", 32'(lg_data[c+19]),  32'hB0);
`else
        tmo_seen = 0;
        for (int i = c; i < c + 22; i++) if (lg_tmo[i]) tmo_seen++;
        chk("t5_no_tmo", 32'(tmo_seen),       32'd0);
        chk("t5_held",   32'(lg_busy[c+18]),  32'd1);
        chk("t5_owner",  32'(lg_grant[c+19]), 32'b001);
`endif

        // 6: asynchronous reset mid-message, then restart from requester 0
        reset_dut();
        c = cyc;
        push(0, 8'h01, 1'b0); push(0, 8'h02, 1'b1);
        repeat (3) run_cycle();
        push(1, 8'h10, 1'b0); push(1, 8'h11, 1'b0); push(1, 8'h12, 1'b1);
        repeat (2) run_cycle();
        chk("t6_owner1", 32'(lg_grant[c+4]), 32'b010);
        drive();
        #2;
        rstn = 1'b0;
        #1;
        chk("t6_arst_busy",  32'(busy),      32'd0);
        chk("t6_arst_grant", 32'(grant),     32'd0);
        chk("t6_arst_valid", 32'(in_valid),  32'd0);
        chk("t6_arst_ready", 32'(req_ready), 32'd0);
        chk("t6_arst_data",  32'(in_data),   32'd0);
        reset_dut();
        c = cyc;
        push(1, 8'h21, 1'b1);
        push(0, 8'h20, 1'b1);
        repeat (6) run_cycle();
        chk("t6_restart", 32'(lg_grant[c+1]), 32'b001);
        chk("t6_r_data",  32'(lg_data[c+1]),  32'h20);
        chk("t6_next",    32'(lg_grant[c+3]), 32'b010);

        // 7: randomized traffic against the model
        rand_gaps = 1'b1;
        repeat (600) begin
            if ($urandom_range(0, 7) == 0) begin
                k = int'($urandom_range(0, N - 1));
                if (rq[k].size() < 8) begin
                    len = int'($urandom_range(1, 4));
                    for (int i = 0; i < len; i++) push(k, 8'($urandom), (i == len - 1));
                end
            end
            in_ready = ($urandom_range(0, 9) < 7);
            run_cycle();
        end
        in_ready = 1'b1;
        repeat (80) run_cycle();
        left = 0;
        for (int i = 0; i < N; i++) left += rq[i].size();
        chk("t7_drained", 32'(left), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_cdc_tx_arbiter
